// File: rtl/irq_sequencer.sv
// Interrupt entry sequencer: arbitrates NMI / INTR / single-step at instruction boundaries,
// runs the two-cycle INTA handshake, dispatches a vector and clears IF/TF. Option: IRQ_SINGLE_STEP_EN.
module irq_sequencer #(
    parameter logic [7:0] NMI_VECTOR   = 8'h02,
    parameter logic [7:0] STEP_VECTOR  = 8'h01,
    parameter int         INTA_TIMEOUT = 16,
    parameter int         UPD_TF       = 5,
    parameter int         UPD_IF       = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] flags,
    input  logic        inst_boundary,
    input  logic        irq_inhibit,
    input  logic        nmi,
    input  logic        intr,
    output logic        inta_req,
    input  logic        inta_ack,
    input  logic [7:0]  inta_data,
    output logic        irq_start,
    output logic [7:0]  irq_vector,
    input  logic        irq_ready,
    output logic [15:0] flags_in,
    output logic [8:0]  update_flags,
    output logic        inta_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        INTA1,
        INTA2,
        DISPATCH,
        CLEAR
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(INTA_TIMEOUT - 1);
    localparam logic [8:0] CLR_MASK  = (9'd1 << UPD_IF) | (9'd1 << UPD_TF);

    state_t     state;
    logic       nmi_q;
    logic       nmi_pending;
    logic [7:0] count;
    logic       step_req;
    logic       unused_flags;

`ifdef IRQ_SINGLE_STEP_EN
    assign step_req = flags[8];
`else
    assign step_req = 1'b0;
`endif

    assign unused_flags = ^{flags[15:10], flags[8:0]};

    // Entry always writes IF and TF as zero; no other flag is ever touched.
    assign flags_in = 16'h0000;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            nmi_q        <= 1'b0;
            nmi_pending  <= 1'b0;
            count        <= 8'd0;
            inta_req     <= 1'b0;
            irq_start    <= 1'b0;
            irq_vector   <= 8'h00;
            update_flags <= 9'd0;
            inta_timeout <= 1'b0;
        end else begin
            nmi_q <= nmi;
            case (state)
                IDLE: begin
                    if (inst_boundary && !irq_inhibit) begin
                        if (nmi_pending) begin
                            irq_vector  <= NMI_VECTOR;
                            nmi_pending <= 1'b0;
                            irq_start   <= 1'b1;
                            state       <= DISPATCH;
                        end else if (intr && flags[9]) begin
                            inta_req <= 1'b1;
                            count    <= 8'd0;
                            state    <= INTA1;
                        end else if (step_req) begin
                            irq_vector <= STEP_VECTOR;
                            irq_start  <= 1'b1;
                            state      <= DISPATCH;
                        end
                    end
                end
                INTA1: begin
                    if (inta_ack) begin
                        inta_req <= 1'b0;
                        count    <= 8'd0;
                        state    <= INTA2;
                    end else if (count == LAST_WAIT) begin
                        inta_req     <= 1'b0;
                        inta_timeout <= 1'b1;
                        count        <= 8'd0;
                        state        <= IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                INTA2: begin
                    // First INTA2 cycle is the mandatory one-cycle gap with inta_req low.
                    if (!inta_req) begin
                        inta_req <= 1'b1;
                    end else if (inta_ack) begin
                        irq_vector   <= inta_data;
                        inta_timeout <= 1'b0;
                        inta_req     <= 1'b0;
                        count        <= 8'd0;
                        irq_start    <= 1'b1;
                        state        <= DISPATCH;
                    end else if (count == LAST_WAIT) begin
                        inta_req     <= 1'b0;
                        inta_timeout <= 1'b1;
                        count        <= 8'd0;
                        state        <= IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DISPATCH: begin
                    if (irq_ready) begin
                        irq_start    <= 1'b0;
                        update_flags <= CLR_MASK;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    update_flags <= 9'd0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A fresh edge landing on the dispatch cycle re-arms the request rather than being lost.
            if (nmi && !nmi_q) begin
                nmi_pending <= 1'b1;
            end
        end
    end

endmodule
